// File: rtl/alu_pkg.sv
// Shared ALU definitions: func3 opcodes and the sequential-multiplier state type.
package alu_pkg;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SLT   = 3'b010;
  localparam logic [2:0] F3_PASS2 = 3'b011;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_SRL   = 3'b101;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle shared ALU; subsra selects SUB for func3 000 and SRA for func3 101.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [2:0]  func3,
  input  logic        subsra,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (func3)
      F3_ADD:   result = subsra ? (op1 - op2) : (op1 + op2);
      F3_SLL:   result = op1 << op2[4:0];
      F3_SLT:   result = {31'd0, ($signed(op1) < $signed(op2))};
      F3_PASS2: result = op2;
      F3_XOR:   result = op1 ^ op2;
      F3_SRL:   result = subsra ? 32'($signed(op1) >>> op2[4:0]) : (op1 >> op2[4:0]);
      F3_OR:    result = op1 | op2;
      F3_AND:   result = op1 & op2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier controller producing the low 32 bits of a product
// by borrowing the shared ALU for one ADD per iteration.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MULstart,
  input  logic [31:0] MULoperand1,
  input  logic [31:0] MULoperand2,
  output logic        MULbusy,
  output logic        MULdone,
  output logic [31:0] MULresult,
  output logic        MULaluSel,
  output logic [31:0] MULaluOp1,
  output logic [31:0] MULaluOp2,
  output logic [2:0]  MULaluFunc3,
  output logic        MULaluSubsra,
  input  logic [31:0] MULaluResult
);

  mul_state_t  state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic        run;
  logic        term;

  assign run = (state == RUN);

  // Early exit looks at the multiplier as it will be after this iteration's shift.
  always_comb begin
    term = (cnt == 5'd31);
    if (EARLY_EXIT && (mplier[31:1] == '0))
      term = 1'b1;
  end

  always_comb begin
    MULaluOp1    = '0;
    MULaluOp2    = '0;
    MULaluFunc3  = F3_ADD;
    MULaluSubsra = 1'b0;
    if (run) begin
      MULaluOp1 = acc;
      MULaluOp2 = mplier[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      MULbusy   <= 1'b0;
      MULdone   <= 1'b0;
      MULaluSel <= 1'b0;
      MULresult <= '0;
    end else begin
      case (state)
        IDLE: begin
          MULdone <= 1'b0;
          if (MULstart) begin
            mcand     <= MULoperand1;
            mplier    <= MULoperand2;
            acc       <= '0;
            cnt       <= '0;
            MULbusy   <= 1'b1;
            MULaluSel <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          acc    <= MULaluResult;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          // The final sum comes straight from the ALU so the result is valid in DONE.
          if (term) begin
            MULresult <= MULaluResult;
            MULdone   <= 1'b1;
            MULaluSel <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          MULdone <= 1'b0;
          MULbusy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          MULdone   <= 1'b0;
          MULbusy   <= 1'b0;
          MULaluSel <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (early exit on/off) closed through the ALU and mux.
module tb_alu_mul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start  [2];
  logic [31:0] opa    [2];
  logic [31:0] opb    [2];
  logic        busy   [2];
  logic        done   [2];
  logic [31:0] result [2];
  logic        sel    [2];
  logic [31:0] aop1   [2];
  logic [31:0] aop2   [2];
  logic [2:0]  af3    [2];
  logic        asub   [2];
  logic [31:0] ares   [2];

  // Datapath side of the mux carries unrelated traffic whenever the multiplier is not selected.
  logic [31:0] dp_op1 = '0;
  logic [31:0] dp_op2 = '0;
  logic [2:0]  dp_f3  = '0;
  logic        dp_sub = 1'b0;
  always @(negedge clk) begin
    dp_op1 <= $urandom;
    dp_op2 <= $urandom;
    dp_f3  <= 3'($urandom);
    dp_sub <= 1'($urandom);
  end

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic [31:0] m_op1, m_op2;
    logic [2:0]  m_f3;
    logic        m_sub;
    assign m_op1 = sel[g] ? aop1[g] : dp_op1;
    assign m_op2 = sel[g] ? aop2[g] : dp_op2;
    assign m_f3  = sel[g] ? af3[g]  : dp_f3;
    assign m_sub = sel[g] ? asub[g] : dp_sub;

    alu u_alu (
      .op1    (m_op1),
      .op2    (m_op2),
      .func3  (m_f3),
      .subsra (m_sub),
      .result (ares[g])
    );

    alu_mul_seq #(.EARLY_EXIT(g == 0)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .MULstart     (start[g]),
      .MULoperand1  (opa[g]),
      .MULoperand2  (opb[g]),
      .MULbusy      (busy[g]),
      .MULdone      (done[g]),
      .MULresult    (result[g]),
      .MULaluSel    (sel[g]),
      .MULaluOp1    (aop1[g]),
      .MULaluOp2    (aop2[g]),
      .MULaluFunc3  (af3[g]),
      .MULaluSubsra (asub[g]),
      .MULaluResult (ares[g])
    );
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int ref_iters(input bit early, input logic [31:0] b);
    int n;
    if (!early) return 32;
    n = 1;
    for (int i = 0; i < 32; i++)
      if (b[i]) n = i + 1;
    return n;
  endfunction

  // Called at the falling edge of cycle t+1 after the accepting edge; k0 > 1 resumes later.
  task automatic watch(input int d, input logic [31:0] a, input logic [31:0] b,
                       input int k0, input string tag);
    int          exp_n;
    logic [31:0] exp_p;
    int          done_at, done_cnt, sel_cnt, busy_cnt, bad;
    logic [31:0] res_at_done;
    exp_n = ref_iters(d == 0, b);
    exp_p = a * b;
    done_at = -1; done_cnt = 0; sel_cnt = k0 - 1; busy_cnt = k0 - 1; bad = 0;
    res_at_done = 'x;
    for (int k = k0; k <= 40; k++) begin
      if (done[d]) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          res_at_done = result[d];
        end
      end
      if (sel[d]) sel_cnt++;
      if (busy[d]) busy_cnt++;
      if (af3[d] !== 3'b000 || asub[d] !== 1'b0) bad++;
      if (!sel[d] && (aop1[d] !== '0 || aop2[d] !== '0)) bad++;
      if (done_at > 0 && k > done_at) break;
      @(negedge clk);
    end
    check({tag, ".done_cycle"}, done_at, exp_n + 1);
    check({tag, ".done_width"}, done_cnt, 1);
    check({tag, ".result"}, res_at_done, exp_p);
    check({tag, ".result_held"}, result[d], exp_p);
    check({tag, ".sel_cycles"}, sel_cnt, exp_n);
    check({tag, ".busy_cycles"}, busy_cnt, exp_n + 1);
    check({tag, ".alu_drive"}, bad, 0);
  endtask

  // Called at a falling edge with the instance idle; returns at the falling edge of t+1.
  task automatic launch(input int d, input logic [31:0] a, input logic [31:0] b);
    start[d] = 1'b1;
    opa[d]   = a;
    opb[d]   = b;
    @(negedge clk);
    start[d] = 1'b0;
    opa[d]   = $urandom;
    opb[d]   = $urandom;
  endtask

  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input string tag);
    launch(d, a, b);
    watch(d, a, b, 1, tag);
  endtask

  initial begin
    int d;
    logic [31:0] a, b;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      opa[i]   = '0;
      opb[i]   = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d.busy", i), busy[i], 0);
      check($sformatf("reset%0d.done", i), done[i], 0);
      check($sformatf("reset%0d.sel", i), sel[i], 0);
      check($sformatf("reset%0d.result", i), result[i], 0);
      check($sformatf("reset%0d.aop", i), aop1[i] | aop2[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 32'd6, 32'd7, "e1_6x7");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "e1_ones");
    run_op(0, 32'h1234_5678, 32'h0, "e1_zero");
    run_op(0, 32'h0001_0000, 32'h0001_0000, "e1_wrap");
    run_op(1, 32'd3, 32'd2, "e0_3x2");
    run_op(1, 32'h8000_0001, 32'h0, "e0_zero");

    // A start pulse during RUN is dropped; one held through DONE waits for IDLE.
    launch(0, 32'd6, 32'd7);
    @(negedge clk);
    start[0] = 1'b1;
    opa[0]   = 32'd9;
    opb[0]   = 32'd9;
    watch(0, 32'd6, 32'd7, 2, "ignore");
    @(negedge clk);
    start[0] = 1'b0;
    watch(0, 32'd9, 32'd9, 1, "retry");

    // Reset in cycle t+5 of a full-length run.
    launch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", busy[0], 0);
    check("abort.sel", sel[0], 0);
    check("abort.result", result[0], 0);
    begin
      int pulses = 0;
      for (int k = 0; k < 40; k++) begin
        if (done[0]) pulses++;
        @(negedge clk);
      end
      check("abort.no_done", pulses, 0);
    end

    for (int i = 0; i < 24; i++) begin
      d = i % 2;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op(d, a, b, $sformatf("rand%0d_%0d", i, d));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
